// File: rtl/adc_sar_ctrl.sv
// Successive-approximation ADC controller: drives the sampling switch and the DAC trial code,
// resolves one bit per clock and emits each finished code with a registered one-cycle strobe.
module adc_sar_ctrl #(
  parameter int unsigned RES           = 10,
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable_in,
  input  logic           comparator_in,
  output logic           sample_out,
  output logic [RES-1:0] dac_out,
  output logic [RES-1:0] data_out,
  output logic           data_valid_strobe,
  output logic           busy_out
);

  localparam int unsigned KW = (RES > 1) ? $clog2(RES) : 1;
  localparam int unsigned SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  localparam logic [KW-1:0]  KTop   = KW'(RES - 1);
  localparam logic [SW-1:0]  SLoad  = SW'(SAMPLE_CYCLES - 1);
  localparam logic [RES-1:0] DacMsb = {1'b1, {(RES - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StConv,
    StHold,
    StStrobe
  } state_e;

  state_e         state_q;
  logic [KW-1:0]  bit_q;
  logic [SW-1:0]  cnt_q;
  logic [RES-1:0] code_q;
  logic [RES-1:0] code_d;
  logic [RES-1:0] dac_trial;

  // Resolve the current bit, then set the next-lower bit as the following trial.
  always_comb begin
    code_d         = code_q;
    code_d[bit_q]  = comparator_in;
    dac_trial      = code_d;
    if (bit_q != '0) begin
      dac_trial[bit_q - 1'b1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      bit_q             <= '0;
      cnt_q             <= '0;
      code_q            <= '0;
      sample_out        <= 1'b0;
      dac_out           <= '0;
      data_out          <= '0;
      data_valid_strobe <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable_in) begin
            state_q    <= StSample;
            sample_out <= 1'b1;
            busy_out   <= 1'b1;
            code_q     <= '0;
            cnt_q      <= SLoad;
          end
        end
        StSample: begin
          if (cnt_q == '0) begin
            state_q    <= StConv;
            sample_out <= 1'b0;
            dac_out    <= DacMsb;
            bit_q      <= KTop;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StConv: begin
          code_q <= code_d;
          if (bit_q == '0) begin
            state_q  <= StHold;
            data_out <= code_d;
            dac_out  <= '0;
          end else begin
            dac_out <= dac_trial;
            bit_q   <= bit_q - 1'b1;
          end
        end
        StHold: begin
          state_q           <= StStrobe;
          data_valid_strobe <= 1'b1;
        end
        StStrobe: begin
          data_valid_strobe <= 1'b0;
          if (enable_in) begin
            state_q    <= StSample;
            sample_out <= 1'b1;
            code_q     <= '0;
            cnt_q      <= SLoad;
          end else begin
            state_q  <= StIdle;
            busy_out <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Bench for adc_sar_ctrl: two instances (RES=10/SC=2 and RES=8/SC=1) driven by a comparator
// model, with every cycle of each conversion checked against an arithmetic SAR reference.
module tb_adc_sar_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_a = 1'b0, cmp_a, smp_a, stb_a, bsy_a;
  logic [9:0] dac_a, dat_a;
  logic       en_b = 1'b0, cmp_b, smp_b, stb_b, bsy_b;
  logic [7:0] dac_b, dat_b;

  int         mode_a = 0, mode_b = 0;   // 0 ideal, 1 tied high, 2 tied low
  logic [9:0] tgt_a = '0;
  logic [7:0] tgt_b = '0;

  always_comb cmp_a = (mode_a == 1) ? 1'b1 : (mode_a == 2) ? 1'b0 : (tgt_a >= dac_a);
  always_comb cmp_b = (mode_b == 1) ? 1'b1 : (mode_b == 2) ? 1'b0 : (tgt_b >= dac_b);

  adc_sar_ctrl #(.RES(10), .SAMPLE_CYCLES(2)) u_dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_in        (en_a),
    .comparator_in    (cmp_a),
    .sample_out       (smp_a),
    .dac_out          (dac_a),
    .data_out         (dat_a),
    .data_valid_strobe(stb_a),
    .busy_out         (bsy_a)
  );

  adc_sar_ctrl #(.RES(8), .SAMPLE_CYCLES(1)) u_dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_in        (en_b),
    .comparator_in    (cmp_b),
    .sample_out       (smp_b),
    .dac_out          (dac_b),
    .data_out         (dat_b),
    .data_valid_strobe(stb_b),
    .busy_out         (bsy_b)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] last_code[2];
  int         last_stb[2];
  logic [9:0] seen_dac[10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic observe(input int sel, output logic s, output logic b, output logic st,
                         output logic [9:0] d, output logic [9:0] q);
    if (sel == 0) begin
      s = smp_a; b = bsy_a; st = stb_a; d = dac_a; q = dat_a;
    end else begin
      s = smp_b; b = bsy_b; st = stb_b; d = {2'b00, dac_b}; q = {2'b00, dat_b};
    end
  endtask

  // Trial j of a binary search toward t: keep t's top j bits, then try the next bit.
  function automatic logic [9:0] trial_of(input int res, input logic [9:0] t, input int j);
    int unsigned tv;
    int unsigned sh;
    int unsigned hi;
    tv = 32'(t);
    sh = 32'(res - j);
    hi = (tv >> sh) << sh;
    return 10'(hi | (32'd1 << (res - 1 - j)));
  endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) en_a = v;
    else en_b = v;
  endtask

  // Runs one conversion from just before its E0 edge; drop_at < 0 keeps enable high.
  task automatic conv(input int sel, input int mode, input logic [9:0] tgt, input int drop_at,
                      input bit chk_gap);
    int sc;
    int res;
    int p;
    logic [9:0] t_eff;
    logic [9:0] prev;
    logic [9:0] exp_d;
    logic s, b, st;
    logic [9:0] d, q;
    logic en_now;
    sc = (sel == 0) ? 2 : 1;
    res = (sel == 0) ? 10 : 8;
    p = sc + res + 2;
    prev = last_code[sel];
    if (sel == 0) begin
      mode_a = mode; tgt_a = tgt;
    end else begin
      mode_b = mode; tgt_b = tgt[7:0];
    end
    t_eff = (mode == 1) ? 10'((32'd1 << res) - 1) : (mode == 2) ? 10'd0 : tgt;
    set_en(sel, 1'b1);
    for (int i = 0; i < p; i++) begin
      @(posedge clk);
      @(negedge clk);
      observe(sel, s, b, st, d, q);
      if (i < sc || i >= sc + res) exp_d = '0;
      else exp_d = trial_of(res, t_eff, i - sc);
      if (i >= sc && i < sc + res) seen_dac[i - sc] = d;
      check($sformatf("d%0d sample E%0d", sel, i), 32'(s), 32'(i < sc));
      check($sformatf("d%0d busy E%0d", sel, i), 32'(b), 32'd1);
      check($sformatf("d%0d dac E%0d", sel, i), 32'(d), 32'(exp_d));
      check($sformatf("d%0d data E%0d", sel, i), 32'(q),
            32'((i < sc + res) ? prev : t_eff));
      check($sformatf("d%0d strobe E%0d", sel, i), 32'(st), 32'(i == sc + res + 1));
      if (i == sc + res + 1) begin
        if (chk_gap) check($sformatf("d%0d strobe period", sel), 32'(cyc - last_stb[sel]), 32'(p));
        last_stb[sel] = cyc;
      end
      if (i == drop_at) set_en(sel, 1'b0);
    end
    last_code[sel] = t_eff;
    en_now = (sel == 0) ? en_a : en_b;
    if (!en_now) begin
      @(posedge clk);
      @(negedge clk);
      observe(sel, s, b, st, d, q);
      check($sformatf("d%0d busy after end", sel), 32'(b), 32'd0);
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        observe(sel, s, b, st, d, q);
        check($sformatf("d%0d idle sample %0d", sel, i), 32'(s), 32'd0);
        check($sformatf("d%0d idle strobe %0d", sel, i), 32'(st), 32'd0);
      end
    end
  endtask

  logic [9:0] ref_seq[10];

  initial begin
    last_code[0] = '0; last_code[1] = '0;
    last_stb[0] = 0; last_stb[1] = 0;
    repeat (2) @(negedge clk);
    check("rst sample", 32'(smp_a), 32'd0);
    check("rst dac", 32'(dac_a), 32'd0);
    check("rst data", 32'(dat_a), 32'd0);
    check("rst strobe", 32'(stb_a), 32'd0);
    check("rst busy", 32'(bsy_a), 32'd0);
    check("rst busy b", 32'(bsy_b), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Ideal comparator at 0x222, with the literal trial sequence checked too.
    conv(0, 0, 10'h222, 0, 1'b0);
    ref_seq = '{10'h200, 10'h300, 10'h280, 10'h240, 10'h220,
                10'h230, 10'h228, 10'h224, 10'h222, 10'h223};
    for (int j = 0; j < 10; j++) check($sformatf("seq222 %0d", j), 32'(seen_dac[j]), 32'(ref_seq[j]));

    conv(0, 1, 10'h000, 3, 1'b0);
    conv(0, 2, 10'h3ff, 0, 1'b0);
    for (int j = 0; j < 10; j++) check($sformatf("seq0 %0d", j), 32'(seen_dac[j]), 32'(10'h200 >> j));

    // Back-to-back codes 0..3, enable dropped at E5 of the last one.
    conv(0, 0, 10'd0, -1, 1'b0);
    conv(0, 0, 10'd1, -1, 1'b1);
    conv(0, 0, 10'd2, -1, 1'b1);
    conv(0, 0, 10'd3, 5, 1'b1);

    for (int r = 0; r < 4; r++) conv(0, 0, 10'($urandom_range(0, 1023)), $urandom_range(0, 12), 1'b0);

    conv(1, 0, 10'h0a5, 0, 1'b0);
    conv(1, 0, 10'($urandom_range(0, 255)), -1, 1'b0);
    conv(1, 0, 10'($urandom_range(0, 255)), 4, 1'b1);

    // Reset at E7 of a conversion.
    en_a = 1'b1;
    mode_a = 0;
    tgt_a = 10'h155;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    en_a = 1'b0;
    #1;
    check("midrst sample", 32'(smp_a), 32'd0);
    check("midrst dac", 32'(dac_a), 32'd0);
    check("midrst data", 32'(dat_a), 32'd0);
    check("midrst strobe", 32'(stb_a), 32'd0);
    check("midrst busy", 32'(bsy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_code[0] = '0;
    last_code[1] = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("postrst strobe %0d", i), 32'(stb_a), 32'd0);
      check($sformatf("postrst busy %0d", i), 32'(bsy_a), 32'd0);
      check($sformatf("postrst sample %0d", i), 32'(smp_a), 32'd0);
    end
    conv(0, 0, 10'($urandom_range(0, 1023)), 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
